slave_msg_poller: RTL and testbench
===================================

Name: slave_msg_poller

Overview:
- Bus-master counterpart of the functional-test slaves: collects their outbound messages over the shared have_msg/len/data/rdreq slave bus.
- Scans slave channels round-robin and drains one message per grant from the selected show-ahead FIFO.
- Frames each message as a byte packet on a valid/ready stream feeding the host link transmitter (UART/USB TX).
- Sits between the slave array (channel 4 = BOS video readback) and the host TX.

Parameters:
N_CH, 5, number of slave channels (max 8)
SYNC_BYTE, 8'hAA, packet start marker

Ports:
sys_clk  in  1  system clock, all logic on rising edge
n_rst  in  1  synchronous active-low reset
have_msg_bus  in  N_CH  per-channel "message pending"
len_bus  in  8*N_CH  per-channel pending byte count, channel k at [8k+7:8k]
slave_data_bus  in  8*N_CH  per-channel show-ahead FIFO head byte
rdreq_bus  out  N_CH  per-channel pop strobe
tx_data  out  8  packet byte to host TX
tx_valid  out  1  tx_data valid
tx_ready  in  1  host TX accepts byte
busy  out  1  packet in progress
cur_ch  out  3  channel being serviced
underrun  out  1  sticky: slave ran dry mid-packet

Behaviour:
- Reset (sync, n_rst=0 at sys_clk edge):
  - tx_valid=0, tx_data=0, busy=0, cur_ch=0, underrun=0, rr pointer=0, state=SCAN.
  - rdreq_bus=0 during and on the cycle after reset.
  - Reset mid-packet abandons the packet; no further rdreq is issued.
- Packet format: SYNC_BYTE, channel index (zero-extended), LEN, LEN payload bytes, CSUM.
  - CSUM = XOR of channel byte, LEN and every payload byte as transmitted, including padding bytes.
- Handshake:
  - tx_data/tx_valid are registers; a byte is accepted on a cycle with tx_valid&tx_ready.
  - tx_data is held stable while tx_valid=1 and tx_ready=0.
  - After each acceptance tx_valid is 0 for exactly one cycle, then the next byte is presented. This bubble covers show-ahead FIFO head-update latency; max throughput is 1 byte per 2 cycles.
- rdreq:
  - rdreq_bus[cur_ch] is combinational = (state==PAYLOAD) & tx_valid & tx_ready & !pad.
  - Exactly one pulse per real payload byte accepted; all other bits are 0.
  - Never asserted outside PAYLOAD.
- States:
  - SCAN: each cycle examine channel ptr.
    - If have_msg[ptr] & len[ptr]!=0: latch cur_ch=ptr, cnt=len[ptr], busy=1, go to SYNC.
    - Otherwise ptr = (ptr==N_CH-1) ? 0 : ptr+1.
    - have_msg with len=0 is skipped with no rdreq.
  - SYNC -> CHAN -> LEN: each presents its byte and advances on acceptance.
  - PAYLOAD: present slave_data_bus[cur_ch] (or 8'h00 if pad).
    - On acceptance cnt decrements; cnt reaching 0 -> CSUM.
    - LEN latched at grant; later changes to len_bus are ignored.
  - Underrun: if have_msg[cur_ch]=0 when a payload byte is about to be presented, set pad=1 and underrun=1.
    - Remaining bytes are 8'h00, no rdreq.
    - pad clears at packet end; underrun clears only on reset.
  - CSUM: present checksum. On acceptance: busy=0, ptr = (cur_ch==N_CH-1) ? 0 : cur_ch+1, go to SCAN.
- Fairness: a channel is rescanned only after all other channels are examined. Worst-case grant latency is N_CH-1 packets.
- Width rules:
  - cnt is 8 bits; LEN=255 is legal.
  - Channel index ≥ N_CH never occurs; rr pointer wraps at N_CH-1.

Test Plan:
- Ch4 pending, LEN=3, FIFO 11,22,33, tx_ready=1 -> stream AA 04 03 11 22 33 07; rdreq_bus[4] pulses exactly 3 times; 1-cycle tx_valid gap after every byte; busy high from grant to CSUM acceptance.
- Same as above, tx_ready=0 for 10 cycles while byte 22 presented -> tx_data holds 22, no rdreq during stall, single rdreq on the acceptance cycle, stream unchanged.
- Ch0 and ch2 pending (LEN=1, data 5A and C3) -> packet ch0 first (AA 00 01 5A 5B), then ch2 (AA 02 01 C3 C0); then ch1 and ch3 pending -> ch3 served before ch1 (ptr resumes at 3).
- Ch1 have_msg=1, LEN=0, no other channel pending -> no tx_valid, no rdreq, scan keeps cycling.
- Ch4 LEN=4, have_msg drops after 2 pops (data 10,20) -> AA 04 04 10 20 00 00 30; exactly 2 rdreq pulses; underrun=1 and stays 1 across later packets.
- n_rst=0 for one cycle mid-PAYLOAD -> next cycle tx_valid=0, busy=0, rdreq=0, underrun=0; next packet begins with AA from ch0-based scan.

Source files
------------

// File: rtl/slave_msg_poller.sv
// slave_msg_poller: round-robin bus master that drains one message per grant
// from the functional-test slaves and frames it as SYNC, CH, LEN, payload, CSUM.
// Latency: grant one cycle after the channel is scanned, first byte one cycle
// later. Each accepted byte is followed by a one-cycle tx_valid bubble.
// Backpressure: tx_valid/tx_data are held while tx_ready=0, and no rdreq is
// issued until the payload byte is accepted.
//
// Ports:
//   sys_clk, n_rst              clock and synchronous active-low reset
//   have_msg_bus, len_bus       per-channel pending flag and byte count (ch k at [8k+7:8k])
//   slave_data_bus, rdreq_bus   per-channel show-ahead FIFO head byte and pop strobe
//   tx_data, tx_valid, tx_ready byte stream to the host transmitter
//   busy, cur_ch, underrun      packet in progress, serviced channel, sticky ran-dry flag
module slave_msg_poller #(
   parameter int         N_CH      = 5,
   parameter logic [7:0] SYNC_BYTE = 8'hAA
) (
   input  logic              sys_clk,
   input  logic              n_rst,
   input  logic [N_CH-1:0]   have_msg_bus,
   input  logic [8*N_CH-1:0] len_bus,
   input  logic [8*N_CH-1:0] slave_data_bus,
   output logic [N_CH-1:0]   rdreq_bus,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              busy,
   output logic [2:0]        cur_ch,
   output logic              underrun
);

   typedef enum logic [2:0] {
      S_SCAN,
      S_SYNC,
      S_CHAN,
      S_LEN,
      S_PAYLOAD,
      S_CSUM
   } state_t;

   state_t     state;
   logic [2:0] ptr;
   logic [7:0] cnt;
   logic [7:0] csum;
   logic       pad;

   logic [7:0] len_arr  [N_CH];
   logic [7:0] data_arr [N_CH];

   for (genvar k = 0; k < N_CH; k++) begin : g_unpack
      assign len_arr[k]  = len_bus[8*k +: 8];
      assign data_arr[k] = slave_data_bus[8*k +: 8];
   end

   function automatic logic [2:0] wrap_inc(input logic [2:0] c);
      return (c == 3'(N_CH - 1)) ? 3'd0 : c + 3'd1;
   endfunction

   // Pop on the same cycle the real payload byte is taken; the bubble that
   // follows gives the slave FIFO a cycle to present its new head. Gated by
   // n_rst so a reset that lands mid-payload cannot pop a byte.
   always_comb begin
      rdreq_bus = '0;
      if (n_rst && (state == S_PAYLOAD) && tx_valid && tx_ready && !pad)
         rdreq_bus[cur_ch] = 1'b1;
   end

   always_ff @(posedge sys_clk) begin
      if (!n_rst) begin
         state    <= S_SCAN;
         ptr      <= 3'd0;
         cnt      <= 8'd0;
         csum     <= 8'd0;
         pad      <= 1'b0;
         tx_data  <= 8'd0;
         tx_valid <= 1'b0;
         busy     <= 1'b0;
         cur_ch   <= 3'd0;
         underrun <= 1'b0;
      end else if (state == S_SCAN) begin
         // A zero-length message is skipped like an idle channel.
         if (have_msg_bus[ptr] && (len_arr[ptr] != 8'd0)) begin
            cur_ch <= ptr;
            cnt    <= len_arr[ptr];
            csum   <= 8'd0;
            pad    <= 1'b0;
            busy   <= 1'b1;
            state  <= S_SYNC;
         end else begin
            ptr <= wrap_inc(ptr);
         end
      end else if (tx_valid) begin
         if (tx_ready) begin
            tx_valid <= 1'b0;
            case (state)
               S_SYNC: state <= S_CHAN;
               S_CHAN: begin
                  csum  <= csum ^ tx_data;
                  state <= S_LEN;
               end
               S_LEN: begin
                  csum  <= csum ^ tx_data;
                  state <= S_PAYLOAD;
               end
               S_PAYLOAD: begin
                  csum <= csum ^ tx_data;
                  cnt  <= cnt - 8'd1;
                  if (cnt == 8'd1)
                     state <= S_CSUM;
               end
               S_CSUM: begin
                  busy  <= 1'b0;
                  pad   <= 1'b0;
                  ptr   <= wrap_inc(cur_ch);
                  state <= S_SCAN;
               end
               default: state <= S_SCAN;
            endcase
         end
      end else begin
         // Bubble cycle: load the byte for the current state.
         tx_valid <= 1'b1;
         case (state)
            S_SYNC: tx_data <= SYNC_BYTE;
            S_CHAN: tx_data <= {5'd0, cur_ch};
            S_LEN:  tx_data <= cnt;  // still equal to LEN: cnt only moves in PAYLOAD
            S_PAYLOAD: begin
               // Once the slave runs dry the rest of the packet is zero
               // padding, so the host still sees the advertised length.
               if (pad || !have_msg_bus[cur_ch]) begin
                  tx_data  <= 8'd0;
                  pad      <= 1'b1;
                  underrun <= 1'b1;
               end else begin
                  tx_data <= data_arr[cur_ch];
               end
            end
            S_CSUM:  tx_data <= csum;
            default: tx_data <= 8'd0;
         endcase
      end
   end

endmodule

// File: tb/tb_slave_msg_poller.sv
module tb_slave_msg_poller;

   localparam int N_CH = 5;

   logic              sys_clk;
   logic              n_rst;
   logic [N_CH-1:0]   have_msg_bus;
   logic [8*N_CH-1:0] len_bus;
   logic [8*N_CH-1:0] slave_data_bus;
   logic [N_CH-1:0]   rdreq_bus;
   logic [7:0]        tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic              busy;
   logic [2:0]        cur_ch;
   logic              underrun;

   slave_msg_poller #(.N_CH(N_CH), .SYNC_BYTE(8'hAA)) dut (
      .sys_clk        (sys_clk),
      .n_rst          (n_rst),
      .have_msg_bus   (have_msg_bus),
      .len_bus        (len_bus),
      .slave_data_bus (slave_data_bus),
      .rdreq_bus      (rdreq_bus),
      .tx_data        (tx_data),
      .tx_valid       (tx_valid),
      .tx_ready       (tx_ready),
      .busy           (busy),
      .cur_ch         (cur_ch),
      .underrun       (underrun)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   // ---------------- slave model: show-ahead FIFOs ----------------
   logic [7:0]      fmem [N_CH][16];
   int              frd    [N_CH];
   int              favail [N_CH];
   logic [7:0]      lenv   [N_CH];
   logic [N_CH-1:0] hm_force;

   always_comb begin
      have_msg_bus   = '0;
      len_bus        = '0;
      slave_data_bus = '0;
      for (int k = 0; k < N_CH; k++) begin
         have_msg_bus[k]          = hm_force[k] | (frd[k] < favail[k]);
         len_bus[8*k +: 8]        = lenv[k];
         slave_data_bus[8*k +: 8] = fmem[k][frd[k] % 16];
      end
   end

   always @(posedge sys_clk) begin
      for (int k = 0; k < N_CH; k++)
         if (rdreq_bus[k]) frd[k] <= frd[k] + 1;
   end

   // ---------------- scoreboard ----------------
   typedef struct packed {
      logic [7:0] b;
      logic       rd;
      logic [2:0] ch;
      logic       last;
   } exp_t;

   exp_t expq[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Load a message into the slave FIFO of channel ch and push the packet the
   // poller must produce for it: only the first 'avail' bytes exist, the rest
   // are zero padding with no pop.
   task automatic load(input int ch, input int n, input int avail, input logic [31:0] d);
      logic [7:0] cs;
      logic [7:0] b;
      for (int i = 0; i < avail; i++)
         fmem[ch][(frd[ch] + i) % 16] = d[31 - 8*i -: 8];
      lenv[ch]   = 8'(n);
      favail[ch] = frd[ch] + avail;
      cs = 8'(ch) ^ 8'(n);
      expq.push_back('{b: 8'hAA, rd: 1'b0, ch: 3'(ch), last: 1'b0});
      expq.push_back('{b: 8'(ch), rd: 1'b0, ch: 3'(ch), last: 1'b0});
      expq.push_back('{b: 8'(n), rd: 1'b0, ch: 3'(ch), last: 1'b0});
      for (int i = 0; i < n; i++) begin
         b = (i < avail) ? d[31 - 8*i -: 8] : 8'h00;
         cs ^= b;
         expq.push_back('{b: b, rd: (i < avail), ch: 3'(ch), last: 1'b0});
      end
      expq.push_back('{b: cs, rd: 1'b0, ch: 3'(ch), last: 1'b1});
   endtask

   // ---------------- monitor ----------------
   initial begin
      exp_t       e;
      logic       prev_acc = 1'b0;
      logic       bub_busy = 1'b0;
      logic       prev_stall = 1'b0;
      logic       exp_idle = 1'b0;
      logic [7:0] prev_data = 8'h00;
      forever begin
         @(negedge sys_clk);
         #1;
         if (!n_rst) begin
            check("rdreq_in_reset", 32'(rdreq_bus), 32'd0);
            prev_acc = 1'b0; bub_busy = 1'b0; prev_stall = 1'b0; exp_idle = 1'b0;
         end else begin
            if (prev_acc) check("bubble", 32'(tx_valid), 32'd0);
            if (bub_busy) check("after_bubble_valid", 32'(tx_valid), 32'd1);
            if (prev_stall) begin
               check("stall_valid", 32'(tx_valid), 32'd1);
               check("stall_hold", 32'(tx_data), 32'(prev_data));
            end
            if (exp_idle) check("busy_clear", 32'(busy), 32'd0);
            exp_idle = 1'b0;
            bub_busy = prev_acc && busy;
            if (tx_valid && tx_ready) begin
               if (expq.size() == 0) begin
                  check("extra_byte", 32'(expq.size()), 32'd1);
               end else begin
                  e = expq.pop_front();
                  check("tx_byte", 32'(tx_data), 32'(e.b));
                  check("busy_in_pkt", 32'(busy), 32'd1);
                  check("cur_ch", 32'(cur_ch), 32'(e.ch));
                  check("rdreq_acc", 32'(rdreq_bus), e.rd ? (32'd1 << e.ch) : 32'd0);
                  exp_idle = e.last;
               end
            end else begin
               check("rdreq_idle", 32'(rdreq_bus), 32'd0);
            end
            prev_acc   = tx_valid && tx_ready;
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic wait_idle(input int budget);
      int n = 0;
      do begin
         @(negedge sys_clk);
         n++;
      end while ((expq.size() != 0 || busy) && n < budget);
      if (n >= budget) check("drain_timeout", 32'(expq.size()) + 32'(busy), 32'd0);
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      logic found;
      int   seen;
      n_rst    = 1'b0;
      tx_ready = 1'b1;
      hm_force = '0;
      for (int k = 0; k < N_CH; k++) begin
         favail[k] = 0;
         lenv[k]   = 8'd0;
         for (int i = 0; i < 16; i++) fmem[k][i] = 8'h00;
      end
      repeat (3) @(negedge sys_clk);
      #1;
      check("rst_tx_valid", 32'(tx_valid), 32'd0);
      check("rst_tx_data", 32'(tx_data), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_cur_ch", 32'(cur_ch), 32'd0);
      check("rst_underrun", 32'(underrun), 32'd0);
      @(negedge sys_clk);
      n_rst = 1'b1;

      // Ch4, LEN=3, full-rate host
      load(4, 3, 3, {8'h11, 8'h22, 8'h33, 8'h00});
      wait_idle(200);

      // Same packet with a 10-cycle stall while 0x22 is presented
      load(4, 3, 3, {8'h11, 8'h22, 8'h33, 8'h00});
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge sys_clk);
         if (tx_valid && tx_data == 8'h22) begin
            found    = 1'b1;
            tx_ready = 1'b0;
         end
      end
      check("stall_reach_22", 32'(found), 32'd1);
      repeat (10) @(negedge sys_clk);
      tx_ready = 1'b1;
      wait_idle(200);

      // Ch0 and ch2 together; ch1 and ch3 queued during ch2 -> ch3 first
      load(0, 1, 1, {8'h5A, 24'h0});
      load(2, 1, 1, {8'hC3, 24'h0});
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge sys_clk);
         if (busy && cur_ch == 3'd2) found = 1'b1;
      end
      check("ch2_granted", 32'(found), 32'd1);
      load(3, 1, 1, {8'h3C, 24'h0});
      load(1, 1, 1, {8'h96, 24'h0});
      wait_idle(400);

      // have_msg with LEN=0 is skipped forever
      lenv[1]     = 8'd0;
      hm_force[1] = 1'b1;
      seen = 0;
      repeat (4 * N_CH) begin
         @(negedge sys_clk);
         if (tx_valid || busy) seen++;
      end
      check("len0_no_packet", 32'(seen), 32'd0);
      hm_force[1] = 1'b0;

      // Underrun: LEN=4 but only two bytes ever arrive
      load(4, 4, 2, {8'h10, 8'h20, 16'h0});
      wait_idle(200);
      check("underrun_set", 32'(underrun), 32'd1);

      // Reset mid-payload; underrun must survive the next packet up to reset
      load(4, 3, 3, {8'h11, 8'h22, 8'h33, 8'h00});
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge sys_clk);
         if (busy && tx_valid && tx_data == 8'h11) found = 1'b1;
      end
      check("reach_payload", 32'(found), 32'd1);
      check("underrun_sticky", 32'(underrun), 32'd1);
      n_rst = 1'b0;
      #1;
      check("rdreq_during_rst", 32'(rdreq_bus), 32'd0);
      @(negedge sys_clk);
      n_rst = 1'b1;
      expq.delete();
      // Rr pointer restarts at 0: ch1 must beat the still-pending ch4
      load(1, 1, 1, {8'hE1, 24'h0});
      load(4, 3, 3, {8'h11, 8'h22, 8'h33, 8'h00});
      #1;
      check("post_rst_valid", 32'(tx_valid), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);
      check("post_rst_underrun", 32'(underrun), 32'd0);
      check("post_rst_rdreq", 32'(rdreq_bus), 32'd0);
      wait_idle(400);
      check("underrun_still_clear", 32'(underrun), 32'd0);

      repeat (3) @(negedge sys_clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
